// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state/phase types and UART register map for the bus sequencer
package uart_pkg;

  typedef enum logic [2:0] {
    S_INIT_BAUD,
    S_INIT_MASK,
    S_IDLE,
    S_RX_STAT,
    S_RX_DATA,
    S_TX_STAT,
    S_TX_DATA
  } sched_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE
  } bus_phase_e;

  localparam logic [1:0] STAT_A = 2'd0;
  localparam logic [1:0] INT_A  = 2'd1;
  localparam logic [1:0] DATA_A = 2'd2;
  localparam logic [1:0] BAUD_A = 2'd3;

endpackage

// File: rtl/uart_bus_sched_if.sv
// rtl/uart_bus_sched_if.sv - UART register-file bus pins (address, strobes, data, interrupt)
interface uart_bus_sched_if;
  logic [1:0] ADDR;
  logic       NCS;
  logic       NO;
  logic       NW;
  logic [7:0] DOUT;
  logic       DOE;
  logic [7:0] DIN;
  logic       NINT;

  modport master (output ADDR, NCS, NO, NW, DOUT, DOE, input DIN, NINT);
  modport slave  (input ADDR, NCS, NO, NW, DOUT, DOE, output DIN, NINT);
endinterface

// File: rtl/uart_bus_phase.sv
// rtl/uart_bus_phase.sv - 2-clock SETUP/STROBE access engine driving the UART bus pins
module uart_bus_phase
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       NRST,
  input  logic       i_start,
  input  logic       i_wr,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_done,
  output logic [7:0] o_rdata,
  uart_bus_sched_if.master bus
);

  bus_phase_e r_phase;
  logic       r_wr;
  logic       w_accept;

  // A new access may start from IDLE or straight out of STROBE (back-to-back).
  assign w_accept = i_start && (r_phase != PH_SETUP);
  assign o_done   = (r_phase == PH_STROBE);
  assign o_rdata  = bus.DIN;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_phase  <= PH_IDLE;
      r_wr     <= 1'b0;
      bus.NCS  <= 1'b1;
      bus.NO   <= 1'b1;
      bus.NW   <= 1'b1;
      bus.ADDR <= 2'd0;
      bus.DOUT <= 8'h00;
      bus.DOE  <= 1'b0;
    end else if (w_accept) begin
      r_phase  <= PH_SETUP;
      r_wr     <= i_wr;
      bus.NCS  <= 1'b0;
      bus.NO   <= 1'b1;
      bus.NW   <= 1'b1;
      bus.ADDR <= i_addr;
      bus.DOUT <= i_wr ? i_wdata : 8'h00;
      bus.DOE  <= i_wr;
    end else if (r_phase == PH_SETUP) begin
      r_phase <= PH_STROBE;
      bus.NO  <= r_wr;
      bus.NW  <= ~r_wr;
    end else begin
      r_phase  <= PH_IDLE;
      bus.NCS  <= 1'b1;
      bus.NO   <= 1'b1;
      bus.NW   <= 1'b1;
      bus.DOUT <= 8'h00;
      bus.DOE  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_bus_sched.sv
// rtl/uart_bus_sched.sv - UART bus sequencer: init, RX service, round-robin TX (optional UART_POLL_TIMEOUT_EN)
module uart_bus_sched
  import uart_pkg::*;
#(
  parameter logic [7:0]  BAUD_DIV  = 8'd26,
  parameter logic [7:0]  INT_MASK  = 8'h02,
  parameter int          TXRDY_BIT = 1,
`ifdef UART_POLL_TIMEOUT_EN
  parameter logic [15:0] TIMEOUT   = 16'd1024,
`endif
  parameter int          RXRDY_BIT = 0
)
(
  input  logic       CLK,
  input  logic       NRST,
  input  logic [1:0] REQ,
  input  logic [7:0] TXBYTE0,
  input  logic [7:0] TXBYTE1,
  output logic [1:0] ACK,
  output logic [7:0] RXBYTE,
  output logic       RXVALID,
  output logic       READY,
`ifdef UART_POLL_TIMEOUT_EN
  output logic       ERR,
`endif
  uart_bus_sched_if.master bus
);

  sched_state_e r_state;
  sched_state_e w_tgt;
  logic         r_ptr;
  logic         r_grant;
  logic [7:0]   r_txbyte;
  logic         w_done;
  logic [7:0]   w_rdata;
  logic         w_start;
  logic         w_wr;
  logic [1:0]   w_addr;
  logic [7:0]   w_wdata;
  logic         w_pick;
  logic         w_poll_expired;

  assign w_pick = REQ[r_ptr] ? r_ptr : ~r_ptr;

`ifdef UART_POLL_TIMEOUT_EN
  logic [15:0] r_poll_cnt;
  assign w_poll_expired = (r_poll_cnt + 16'd1) >= TIMEOUT;
`else
  assign w_poll_expired = 1'b0;
`endif

  // w_tgt is the state that owns the next bus cycle; chaining through it gives back-to-back SETUPs.
  always_comb begin
    w_tgt = r_state;
    if (w_done) begin
      case (r_state)
        S_INIT_BAUD: w_tgt = S_INIT_MASK;
        S_RX_STAT:   w_tgt = w_rdata[RXRDY_BIT] ? S_RX_DATA : S_IDLE;
        S_TX_STAT:   w_tgt = w_rdata[TXRDY_BIT] ? S_TX_DATA :
                             (w_poll_expired ? S_IDLE : S_TX_STAT);
        default:     w_tgt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_start = 1'b1;
    w_wr    = 1'b0;
    w_addr  = STAT_A;
    w_wdata = 8'h00;
    case (w_tgt)
      S_INIT_BAUD: begin w_wr = 1'b1; w_addr = BAUD_A; w_wdata = BAUD_DIV; end
      S_INIT_MASK: begin w_wr = 1'b1; w_addr = INT_A;  w_wdata = INT_MASK; end
      S_RX_DATA:   w_addr = DATA_A;
      S_TX_DATA:   begin w_wr = 1'b1; w_addr = DATA_A; w_wdata = r_txbyte; end
      S_RX_STAT, S_TX_STAT: w_addr = STAT_A;
      default:     w_start = 1'b0;
    endcase
  end

  uart_bus_phase u_phase (
    .CLK     (CLK),
    .NRST    (NRST),
    .i_start (w_start),
    .i_wr    (w_wr),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .bus     (bus)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state  <= S_INIT_BAUD;
      r_ptr    <= 1'b0;
      r_grant  <= 1'b0;
      r_txbyte <= 8'h00;
      ACK      <= 2'b00;
      RXBYTE   <= 8'h00;
      RXVALID  <= 1'b0;
      READY    <= 1'b0;
`ifdef UART_POLL_TIMEOUT_EN
      ERR        <= 1'b0;
      r_poll_cnt <= 16'd0;
`endif
    end else begin
      ACK     <= 2'b00;
      RXVALID <= 1'b0;
`ifdef UART_POLL_TIMEOUT_EN
      ERR     <= 1'b0;
`endif
      if (w_done) begin
        r_state <= w_tgt;
        case (r_state)
          S_INIT_MASK: READY <= 1'b1;
          S_RX_DATA: begin
            RXBYTE  <= w_rdata;
            RXVALID <= 1'b1;
          end
`ifdef UART_POLL_TIMEOUT_EN
          S_TX_STAT: begin
            if (!w_rdata[TXRDY_BIT]) begin
              r_poll_cnt <= r_poll_cnt + 16'd1;
              if (w_poll_expired) begin
                ERR   <= 1'b1;
                r_ptr <= ~r_grant;
              end
            end
          end
`endif
          S_TX_DATA: begin
            ACK[r_grant] <= 1'b1;
            r_ptr        <= ~r_grant;
          end
          default: ;
        endcase
      end else if (r_state == S_IDLE) begin
        if (!bus.NINT) begin
          r_state <= S_RX_STAT;
        end else if (|REQ) begin
          r_state  <= S_TX_STAT;
          r_grant  <= w_pick;
          r_txbyte <= w_pick ? TXBYTE1 : TXBYTE0;
`ifdef UART_POLL_TIMEOUT_EN
          r_poll_cnt <= 16'd0;
`endif
        end
      end
    end
  end

endmodule

// File: doc/uart_bus_sched.md
Name: uart_bus_sched

Overview:
- Bus-master sequencer for the UART register file: status (ADDR 0), interrupt mask (1), data (2), baud divisor (3).
- Runs the init sequence after reset.
- Round-robin arbitrates two byte-transmit requesters onto the single UART data register, gating each write on TX-ready.
- Services receive by reading the data register when NINT asserts, handing the byte to the consumer.

Parameters:
- BAUD_DIV, 8'd26, value written to the baud divisor register during init.
- INT_MASK, 8'h02, value written to the interrupt mask register during init (enables RX-ready interrupt).
- TXRDY_BIT, 1, status bit index meaning the transmit data register is empty.
- RXRDY_BIT, 0, status bit index meaning a received byte is available.
- TIMEOUT, 16'd1024, poll-cycle limit (used only with the optional feature).

Ports:
- CLK  in  1  system clock, all state on rising edge
- NRST  in  1  asynchronous active-low reset
- REQ  in  2  per-requester transmit request, held until ACK
- TXBYTE0  in  8  requester 0 byte, stable while REQ[0]
- TXBYTE1  in  8  requester 1 byte, stable while REQ[1]
- ACK  out  2  one-cycle pulse: byte written to UART
- RXBYTE  out  8  last received byte
- RXVALID  out  1  one-cycle pulse when RXBYTE updates
- READY  out  1  high once init is complete
- ADDR  out  2  UART register address
- NCS  out  1  negative chip select
- NO  out  1  negative read enable
- NW  out  1  negative write enable
- DOUT  out  8  write data to UART
- DOE  out  1  high while DOUT drives the UART DATA bus
- DIN  in  8  read data from UART
- NINT  in  1  UART negative interrupt

Behaviour:
- Reset is async, active-low. While NRST=0 and the cycle after release:
  - NCS=NO=NW=1, ADDR=0, DOUT=0, DOE=0, ACK=0, RXVALID=0, RXBYTE=0, READY=0.
  - Round-robin pointer = 0; FSM = INIT_BAUD.
- Bus cycle is 2 clocks:
  - SETUP: NCS=0, ADDR valid, NO=NW=1; DOE=1 on writes.
  - STROBE: NO=0 or NW=0; DIN is sampled at the end of STROBE.
  - Next cycle: NCS=NO=NW=1, DOE=0.
  - Back-to-back accesses are allowed, each with its own SETUP.
- FSM states and transitions:
  - INIT_BAUD: write BAUD_DIV to addr 3.
  - INIT_MASK: write INT_MASK to addr 1.
  - IDLE: READY=1 from here on.
  - RX_STAT: read addr 0.
  - RX_DATA: read addr 2.
  - TX_STAT: read addr 0.
  - TX_DATA: write addr 2.
- IDLE priority:
  - NINT=0 → RX_STAT.
  - Otherwise, any REQ → grant and go to TX_STAT.
  - RX always beats TX.
- RX path:
  - RX_STAT: if status[RXRDY_BIT]=1 → RX_DATA, else → IDLE (spurious interrupt).
  - RX_DATA: RXBYTE=DIN, RXVALID pulses the cycle after STROBE, → IDLE.
- TX arbitration and path:
  - Grant is latched at IDLE exit: the requester at the pointer if requesting, otherwise the other one.
  - The granted byte is latched into an internal register at grant time.
  - TX_STAT: if status[TXRDY_BIT]=0, re-poll (new SETUP); if 1 → TX_DATA.
  - TX_DATA: DOUT = latched byte; ACK[grant] pulses the cycle after STROBE; pointer = ~grant; → IDLE.
- Boundary conditions:
  - Both REQ high continuously: grants alternate 0,1,0,1.
  - A single requester held high is re-granted every transaction.
  - REQ dropped after grant is ignored; the transaction completes and ACK still pulses.
  - NINT asserting during TX polling does not preempt; it is serviced at the next IDLE.
  - Reset mid-transaction aborts immediately with no ACK, and init reruns.
- Latency:
  - Reset release to READY = 5 clocks (2 writes × 2 + 1).
  - TX with ready status: REQ to ACK = 6 clocks.

Optional Feature:
- Macro: UART_POLL_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on TX_STAT entry and increments per poll.
  - Reaching TIMEOUT abandons the transfer and pulses output ERR (1 bit, reset 0) instead of ACK.
  - The pointer still advances.
- When undefined: no ERR port, polling is unbounded, and the counter is not built.

Decomposition:
- Package uart_pkg holds:
  - The state enum.
  - Register address constants: STAT_A=0, INT_A=1, DATA_A=2, BAUD_A=3.
  - The bus-phase enum (IDLE, SETUP, STROBE).
- One sub-module, uart_bus_phase: the 2-clock access engine. Inputs: start, rd/wr, addr, wdata. Outputs: done, rdata, bus pins.
- The top holds the FSM and arbiter.

Test Plan:
- Reset release, BAUD_DIV=26 → writes 8'h1A@addr3 then 8'h02@addr1; READY=1 at clock 5; no ACK/RXVALID.
- REQ=01, TXBYTE0=8'h41, status=8'h02 → one read at addr0, write 8'h41 at addr2, ACK=01 six clocks after REQ.
- REQ=11 held for 4 transactions with bytes 8'hA0/8'hB1 → writes A0,B1,A0,B1; ACK alternates 01,10.
- Status TXRDY=0 for 3 polls, then 1 → 4 status reads, then data write; with UART_POLL_TIMEOUT_EN and TIMEOUT=2 → ERR pulse, no write, no ACK.
- NINT=0, status=8'h01, DIN at data read=8'h5C → RXBYTE=8'h5C, RXVALID one cycle; with status=8'h00 → no data read, no RXVALID.
- NRST pulsed during TX_DATA SETUP → all bus outputs high/0 immediately, no ACK, init sequence repeats.
